// File: rtl/tpu_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_param_pkg
//  Description : Shared types and constants for the parameter-SRAM read path.
//                Holds the reader state encoding, default SRAM geometry and
//                the write-enable level used for read-only SRAM access.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_param_pkg;

    // Reader control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } param_rd_state_e;

    // Default SRAM geometry: 4 words of 32 bits (16 bytes)
    localparam int c_default_addr_w = 2;
    localparam int c_default_data_w = 32;

    // Active-low write enable held inactive: the reader only ever reads
    localparam logic MEM_READ_WEB = 1'b1;

endpackage : tpu_param_pkg
`default_nettype wire

// File: rtl/param_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_rd_fifo
//  Description : Synchronous first-word-fall-through FIFO. The head entry is
//                visible on o_data whenever o_count is non-zero.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_push, i_data  - write strobe and data
//                i_pop           - consume the head entry
//                o_data          - head entry (fall-through)
//                o_count         - number of stored entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module param_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_pop;

    // Popping an empty FIFO is ignored so the pointers can never cross
    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : param_rd_fifo
`default_nettype wire

// File: rtl/param_sram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : param_sram_reader
//  Description : Streaming read engine for the parameter SRAM. A start pulse
//                reads len consecutive words from base (address wraps),
//                buffers them in a small FIFO and presents them on a
//                valid/ready stream. The SRAM is never written.
//  Ports       : clk, rst_n                    - clock, async active-low reset
//                start, base, len              - transfer request
//                busy, done                    - transfer status
//                mem_cs/oe/web/addr, mem_rdata - single-port SRAM interface
//                out_valid/ready/data          - output stream
//                stall_cnt (optional)          - backpressure cycle counter
//  Options     : define PARAM_SRAM_READER_PERF_EN to add stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_sram_reader
    import tpu_param_pkg::*;
#(
    parameter int ADDR_W     = c_default_addr_w,
    parameter int DATA_W     = c_default_data_w,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_web,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PARAM_SRAM_READER_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    param_rd_state_e   r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic [c_cnt_w-1:0] w_fifo_count;
    logic [DATA_W-1:0]  w_head;
    logic               w_pop;
    logic               w_issue;
    logic [c_cnt_w:0]   w_credit_used;
    logic               w_drain_empty;
    logic [LEN_W-1:0]   w_issued_next;

    // Slots already committed: buffered words plus the read returning this
    // cycle, less the word leaving this cycle. A read may only be issued
    // while a slot remains, which is what makes the unconditional push safe.
    assign w_credit_used = {1'b0, w_fifo_count}
                         + {{c_cnt_w{1'b0}}, r_inflight}
                         - {{c_cnt_w{1'b0}}, w_pop};
    assign w_issue       = (r_state == ST_FETCH) && (w_credit_used < c_depth);
    assign w_issued_next = r_issued + 1'b1;

    // Transfer is complete once nothing is in flight and the last buffered
    // word is being popped this cycle (or the buffer is already empty)
    assign w_drain_empty = !r_inflight
                        && (w_fifo_count == {{(c_cnt_w-1){1'b0}}, w_pop});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_base   <= base;
                            r_len    <= len;
                            r_issued <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_FETCH;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= ST_FINISH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (w_issue) begin
                        r_issued <= w_issued_next;
                        if (w_issued_next == r_len) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_empty) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    param_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (mem_rdata),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_cs    = w_issue;
    assign mem_oe    = r_busy;
    assign mem_web   = MEM_READ_WEB;
    // Address wraps naturally by truncation to ADDR_W bits
    assign mem_addr  = r_base + ADDR_W'(r_issued);
    assign out_valid = (w_fifo_count != '0);
    assign out_data  = w_head;
    assign w_pop     = out_valid && out_ready;

`ifdef PARAM_SRAM_READER_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (((r_state == ST_FETCH) || (r_state == ST_DRAIN))
                     && out_valid && !out_ready
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule : param_sram_reader
`default_nettype wire

// File: tb/tb_param_sram_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_sram_reader
//  Description : Self-checking bench for param_sram_reader. A behavioural
//                SRAM feeds the DUT; expected address and data sequences are
//                derived from base/len with modular arithmetic and consumed
//                as the DUT issues reads and delivers words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sram_reader;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int WORDS      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              mem_cs;
    logic              mem_oe;
    logic              mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef PARAM_SRAM_READER_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    param_sram_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_cs    (mem_cs),
        .mem_oe    (mem_oe),
        .mem_web   (mem_web),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PARAM_SRAM_READER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural SRAM with one-cycle registered read
    logic [DATA_W-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (mem_cs && mem_web) mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference expectations and per-run observations
    int                cyc = 0;
    int                exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    int read_cnt, pop_cnt, done_cnt, done_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
    int stall_model;
    int ready_mode, n_stall, inj_cyc;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    task automatic sample();
        logic pop;
        pop = out_valid && out_ready;
        if (prev_stall) begin
            check("hold_data", out_data, prev_data);
            check("hold_valid", out_valid, 1);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop) begin
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_data.size() == 0) check("spurious_pop", 1, 0);
            else check("out_data", out_data, exp_data.pop_front());
        end
        if (mem_cs) begin
            read_cnt++;
            check("mem_web", mem_web, 1);
            if (exp_addr.size() == 0) check("extra_read", 1, 0);
            else check("mem_addr", mem_addr, exp_addr.pop_front());
            check("outstanding_le_depth", (read_cnt - pop_cnt) <= FIFO_DEPTH, 1);
        end
        if (out_valid && !out_ready) stall_model++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef PARAM_SRAM_READER_PERF_EN
            check("stall_cnt", stall_cnt, stall_model);
`endif
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        start = 1'b0;
        if (inj_cyc == cyc) begin
            start = 1'b1;
            base  = 2'd0;
            len   = 8'd5;
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (first_valid_cyc >= 0) && (cyc >= first_valid_cyc + n_stall);
        endcase
        @(negedge clk);
        sample();
    endtask

    task automatic clear_run();
        exp_addr.delete();
        exp_data.delete();
        read_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        stall_model = 0; inj_cyc = -1;
        prev_stall = 1'b0;
    endtask

    // Must be called at a negedge; leaves the DUT idle at a negedge
    task automatic run(input int b, input int l, input int mode, input int stalls, input bit inject);
        int s;
        clear_run();
        for (int k = 0; k < l; k++) begin
            exp_addr.push_back((b + k) % WORDS);
            exp_data.push_back(mem[(b + k) % WORDS]);
        end
        ready_mode = mode;
        n_stall    = stalls;
        base  = ADDR_W'(b);
        len   = LEN_W'(l);
        start = 1'b1;
        step();
        s = cyc;
        if (inject) inj_cyc = s + 2;
        check("busy_after_start", busy, (l != 0));
        for (int t = 0; t < 300 && done_cnt == 0; t++) step();
        check("done_seen", done_cnt, 1);
        check("addr_all_issued", exp_addr.size(), 0);
        check("data_all_delivered", exp_data.size(), 0);
        if (l > 0) begin
            check("first_valid_latency", first_valid_cyc - s, 2);
            check("done_after_last_pop", done_cyc - last_pop_cyc, 1);
            if (mode == 0) check("one_word_per_cycle", last_pop_cyc - first_pop_cyc, l - 1);
        end else begin
            check("zero_len_done", done_cyc - s, 0);
            check("zero_len_no_read", read_cnt, 0);
            check("zero_len_no_valid", first_valid_cyc < 0, 1);
        end
        inj_cyc = -1;
        step();
        step();
        check("idle_busy", busy, 0);
        check("single_done", done_cnt, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mem_cs"},    mem_cs, 0);
        check({tag, "_mem_oe"},    mem_oe, 0);
        check({tag, "_mem_web"},   mem_web, 1);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data, 0);
`ifdef PARAM_SRAM_READER_PERF_EN
        check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        ready_mode = 0; n_stall = 0;
        clear_run();
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hA0 + i;
        #22;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 4, 0, 0, 1'b0);   // basic burst
        run(0, 4, 2, 5, 1'b0);   // backpressure: 5 stall cycles on first word
        run(3, 3, 0, 0, 1'b0);   // address wrap 3,0,1
        run(0, 0, 0, 0, 1'b0);   // zero length
        run(1, 6, 0, 0, 1'b1);   // second start mid-burst is ignored
        run(0, 4, 2, 3, 1'b0);   // 3 stall cycles

        // Reset mid-transfer
        clear_run();
        for (int k = 0; k < 6; k++) begin
            exp_addr.push_back((2 + k) % WORDS);
            exp_data.push_back(mem[(2 + k) % WORDS]);
        end
        ready_mode = 0;
        base = 2'd2; len = 8'd6; start = 1'b1;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        clear_run();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("held_reset");
        rst_n = 1'b1;
        repeat (4) step();
        check("no_done_after_abort", done_cnt, 0);
        run(2, 4, 0, 0, 1'b0);   // clean transfer after abort

        // Randomized bursts over random memory contents
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int r = 0; r < 10; r++) begin
            run(int'($urandom_range(0, WORDS - 1)), int'($urandom_range(0, 9)), 1, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_sram_reader
`default_nettype wire
